br_resolve_queue: RTL and testbench
===================================

// Module: br_resolve_queue
// PURPOSE
//  In-order queue of in-flight branch predictions between fetch and the local 2-bit counter table.
//  Fetch allocates one entry per predicted branch. Execute resolves entries out of order by tag.
//  The oldest resolved entry retires and drives the counter-table update (index plus taken).
//  On mispredict it raises a front-end redirect and flushes the whole queue.
// PARAMETERS
//  IDX_W    4   predictor index width (matches BR_IDX)
//  DEPTH    8   entries; power of two, >=2
//  PC_W     64  PC/target width
//  TAG_W    $clog2(DEPTH)  entry tag width (derived)
// PORTS
//  clk               in   1      clock, rising edge
//  reset             in   1      asynchronous, active-low reset
//  alloc_valid       in   1      fetch allocates one entry this cycle
//  alloc_pc          in   PC_W   branch PC
//  alloc_idx         in   IDX_W  predictor index used at fetch
//  alloc_pred_taken  in   1      predicted direction
//  alloc_pred_target in   PC_W   predicted target (don't-care if not taken)
//  alloc_ready       out  1      entry available; alloc honoured only when high
//  alloc_tag         out  TAG_W  tag given to the current allocation (= tail pointer)
//  resolve_valid     in   1      execute reports an outcome
//  resolve_tag       in   TAG_W  entry being resolved
//  resolve_taken     in   1      actual direction
//  resolve_target    in   PC_W   actual target (valid when taken)
//  upd_valid         out  1      one-cycle pulse: train predictor
//  upd_idx           out  IDX_W  index to update
//  upd_taken         out  1      actual direction
//  flush_valid       out  1      one-cycle pulse: mispredict redirect
//  flush_target      out  PC_W   correct fetch PC
//  count             out  TAG_W+1  occupied entries
//  stat_retired      out  32     retired-branch counter (see CONFIGURATION)
//  stat_mispred      out  32     mispredict counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset:
//   - All entries FREE; head=tail=0; count=0.
//   - All outputs 0, except alloc_ready=1 and alloc_tag=0.
//  Entry states: FREE -> PENDING (alloc) -> RESOLVED (resolve) -> FREE (retire or flush).
//  alloc_ready:
//   - Equals (count!=DEPTH) && !retire_mispred.
//   - Purely from registered state; no same-cycle bypass of a retiring slot.
//  Alloc: on an edge with alloc_valid && alloc_ready, write tail, set PENDING, tail++ (wraps mod DEPTH).
//  Resolve:
//   - Applies only when the tagged entry is PENDING; otherwise ignored.
//   - Stores taken/target and sets RESOLVED.
//  Retire (at most 1 per cycle):
//   - When head is RESOLVED, the head pops at the next edge.
//   - upd_* are registered and valid the following cycle (1-cycle latency from the RESOLVED state).
//  Mispredict:
//   - Condition: taken != pred_taken, OR (taken && target != pred_target).
//   - retire_mispred = head RESOLVED && mispredict.
//   - On that edge: upd pulse as normal, flush_valid=1.
//   - flush_target = taken ? target : alloc_pc+4 (mod 2^PC_W).
//   - All entries -> FREE; head=tail=0; count=0.
//  Simultaneous events:
//   - Alloc plus normal retire on one edge: count unchanged.
//   - Resolve on the flush edge is discarded.
//   - Alloc on the flush edge is blocked by alloc_ready=0.
//   - Resolve to the head on the same edge does not retire until the next cycle.
//  Wrap: head/tail roll DEPTH-1 -> 0. Full = count==DEPTH, empty = count==0.
//  Async reset mid-operation: immediate return to reset state; pending pulses are dropped.
// CONFIGURATION
//  BR_RESOLVE_STATS_EN:
//   - Defined: stat_retired and stat_mispred count retirements and mispredicts; 32-bit, saturating.
//   - Both clear on reset and survive flushes.
//   - Undefined: both ports are tied to 0 and no counter flops are built.
// STRUCTURE
//  Shared package br_pkg:
//   - BR_IDX/BR_SZ constants.
//   - Entry state enum (FREE/PENDING/RESOLVED).
//   - Entry struct: pc, idx, pred_taken, pred_target, act_taken, act_target.
//  Sub-module br_rq_entry: one slot's storage and state FSM, with alloc/resolve/clear strobes.
//  Top level instantiates DEPTH slots and adds the pointers, mispredict compare and output registers.
// TESTING
//  1. Reset: assert reset=0 mid-traffic -> count=0, alloc_ready=1, no upd/flush pulses.
//  2. Correct path:
//     - Stimulus: alloc 3 not-taken predictions (idx 1,2,3); resolve tags 2,0,1, all not-taken.
//     - Response: upd pulses in order idx 1,2,3 with upd_taken=0; flush_valid never asserts.
//  3. Direction mispredict:
//     - Stimulus: pc=0x100 pred not-taken, resolved taken to 0x200.
//     - Response: upd_taken=1, flush_target=0x200, count=0 next cycle.
//  4. Target mispredict:
//     - Stimulus: pred taken to 0x300, actual 0x340; younger PENDING entries present.
//     - Response: flush_target=0x340; younger entries freed and never produce upd.
//  5. Full/wrap:
//     - Fill DEPTH=8 entries -> alloc_ready=0.
//     - Alloc while head retires -> still blocked that cycle.
//     - Run 20 alloc/retire cycles -> tags wrap 7->0 correctly.
//  6. Stats with BR_RESOLVE_STATS_EN:
//     - Stimulus: 10 retires, including 3 mispredicts.
//     - Response: stat_retired=10, stat_mispred=3. Without the macro both read 0.

Source files
------------

// File: rtl/br_pkg.sv
// Shared branch-queue types: predictor sizing constants, slot state and slot payload.
package br_pkg;

    localparam int BR_IDX  = 4;
    localparam int BR_SZ   = 8;
    localparam int BR_PC_W = 64;

    typedef enum logic [1:0] {
        BR_FREE,
        BR_PENDING,
        BR_RESOLVED
    } br_state_e;

    typedef struct packed {
        logic [BR_PC_W-1:0] pc;
        logic [BR_IDX-1:0]  idx;
        logic               pred_taken;
        logic [BR_PC_W-1:0] pred_target;
        logic               act_taken;
        logic [BR_PC_W-1:0] act_target;
    } br_entry_t;

endpackage

// File: rtl/br_resolve_queue_if.sv
// Fetch/execute/predictor-facing bundle of the branch resolve queue.
interface br_resolve_queue_if
    import br_pkg::*;
#(
    parameter int IDX_W = BR_IDX,
    parameter int DEPTH = BR_SZ,
    parameter int PC_W  = BR_PC_W
);
    localparam int TAG_W = $clog2(DEPTH);

    logic             alloc_valid;
    logic [PC_W-1:0]  alloc_pc;
    logic [IDX_W-1:0] alloc_idx;
    logic             alloc_pred_taken;
    logic [PC_W-1:0]  alloc_pred_target;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             resolve_valid;
    logic [TAG_W-1:0] resolve_tag;
    logic             resolve_taken;
    logic [PC_W-1:0]  resolve_target;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             flush_valid;
    logic [PC_W-1:0]  flush_target;
    logic [TAG_W:0]   count;
    logic [31:0]      stat_retired;
    logic [31:0]      stat_mispred;

    modport master (
        output alloc_valid, alloc_pc, alloc_idx, alloc_pred_taken, alloc_pred_target,
        output resolve_valid, resolve_tag, resolve_taken, resolve_target,
        input  alloc_ready, alloc_tag, upd_valid, upd_idx, upd_taken,
        input  flush_valid, flush_target, count, stat_retired, stat_mispred
    );

    modport slave (
        input  alloc_valid, alloc_pc, alloc_idx, alloc_pred_taken, alloc_pred_target,
        input  resolve_valid, resolve_tag, resolve_taken, resolve_target,
        output alloc_ready, alloc_tag, upd_valid, upd_idx, upd_taken,
        output flush_valid, flush_target, count, stat_retired, stat_mispred
    );

endinterface

// File: rtl/br_rq_entry.sv
// One resolve-queue slot: payload storage plus FREE/PENDING/RESOLVED state.
module br_rq_entry
    import br_pkg::*;
#(
    parameter int  PC_W    = BR_PC_W,
    parameter type entry_t = br_entry_t
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alloc,
    input  entry_t          alloc_entry,
    input  logic            resolve,
    input  logic            resolve_taken,
    input  logic [PC_W-1:0] resolve_target,
    input  logic            clear,
    output br_state_e       state,
    output entry_t          entry
);

    // clear wins over everything; resolve only lands on a PENDING slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BR_FREE;
            entry <= '0;
        end else if (clear) begin
            state <= BR_FREE;
        end else begin
            case (state)
                BR_FREE: begin
                    if (alloc) begin
                        state <= BR_PENDING;
                        entry <= alloc_entry;
                    end
                end
                BR_PENDING: begin
                    if (resolve) begin
                        state            <= BR_RESOLVED;
                        entry.act_taken  <= resolve_taken;
                        entry.act_target <= resolve_target;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/br_resolve_queue.sv
// In-order branch resolve queue: out-of-order resolve, in-order retire/train, flush on mispredict.
// Optional BR_RESOLVE_STATS_EN builds saturating retire/mispredict counters.
module br_resolve_queue
    import br_pkg::*;
#(
    parameter int IDX_W = BR_IDX,
    parameter int DEPTH = BR_SZ,
    parameter int PC_W  = BR_PC_W
) (
    input  logic               clk,
    input  logic               reset,
    br_resolve_queue_if.slave  q
);

    localparam int TAG_W = $clog2(DEPTH);
    localparam logic [TAG_W:0] FULL = DEPTH[TAG_W:0];

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [IDX_W-1:0] idx;
        logic             pred_taken;
        logic [PC_W-1:0]  pred_target;
        logic             act_taken;
        logic [PC_W-1:0]  act_target;
    } slot_t;

    logic [TAG_W-1:0] head, tail;
    logic [TAG_W:0]   count;
    br_state_e        slot_state [DEPTH];
    slot_t            slot_data  [DEPTH];
    slot_t            new_entry, head_entry;
    logic             retire, mispred, retire_mispred, do_alloc;

    always_comb begin
        new_entry             = '0;
        new_entry.pc          = q.alloc_pc;
        new_entry.idx         = q.alloc_idx;
        new_entry.pred_taken  = q.alloc_pred_taken;
        new_entry.pred_target = q.alloc_pred_target;
    end

    assign head_entry     = slot_data[head];
    assign retire         = (slot_state[head] == BR_RESOLVED);
    assign mispred        = (head_entry.act_taken != head_entry.pred_taken) ||
                            (head_entry.act_taken && (head_entry.act_target != head_entry.pred_target));
    assign retire_mispred = retire && mispred;
    assign do_alloc       = q.alloc_valid && q.alloc_ready;

    assign q.alloc_ready  = (count != FULL) && !retire_mispred;
    assign q.alloc_tag    = tail;
    assign q.count        = count;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        br_rq_entry #(
            .PC_W    (PC_W),
            .entry_t (slot_t)
        ) u_entry (
            .clk            (clk),
            .reset          (reset),
            .alloc          (do_alloc && (tail == TAG_W'(g))),
            .alloc_entry    (new_entry),
            .resolve        (q.resolve_valid && (q.resolve_tag == TAG_W'(g)) && !retire_mispred),
            .resolve_taken  (q.resolve_taken),
            .resolve_target (q.resolve_target),
            .clear          (retire_mispred || (retire && (head == TAG_W'(g)))),
            .state          (slot_state[g]),
            .entry          (slot_data[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            q.upd_valid    <= 1'b0;
            q.upd_idx      <= '0;
            q.upd_taken    <= 1'b0;
            q.flush_valid  <= 1'b0;
            q.flush_target <= '0;
        end else begin
            q.upd_valid   <= retire;
            q.flush_valid <= retire_mispred;
            if (retire) begin
                q.upd_idx      <= head_entry.idx;
                q.upd_taken    <= head_entry.act_taken;
                q.flush_target <= head_entry.act_taken ? head_entry.act_target
                                                       : head_entry.pc + PC_W'(4);
            end
            if (retire_mispred) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_alloc) tail <= tail + 1'b1;
                if (retire)   head <= head + 1'b1;
                if (do_alloc && !retire)      count <= count + 1'b1;
                else if (!do_alloc && retire) count <= count - 1'b1;
            end
        end
    end

`ifdef BR_RESOLVE_STATS_EN
    logic [31:0] n_retired, n_mispred;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_retired <= '0;
            n_mispred <= '0;
        end else begin
            if (retire && (n_retired != '1))         n_retired <= n_retired + 1'b1;
            if (retire_mispred && (n_mispred != '1)) n_mispred <= n_mispred + 1'b1;
        end
    end

    assign q.stat_retired = n_retired;
    assign q.stat_mispred = n_mispred;
`else
    assign q.stat_retired = '0;
    assign q.stat_mispred = '0;
`endif

endmodule

// File: tb/tb_br_resolve_queue.sv
// Randomized + directed bench for br_resolve_queue against a queue-based reference model.
module tb_br_resolve_queue;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    br_resolve_queue_if #(.IDX_W(4), .DEPTH(DEPTH), .PC_W(64)) bus ();

    br_resolve_queue #(.IDX_W(4), .DEPTH(DEPTH), .PC_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (bus)
    );

    typedef struct {
        logic [2:0]  tag;
        logic [63:0] pc;
        logic [3:0]  idx;
        bit          pt;
        logic [63:0] ptg;
        bit          res;
        bit          at;
        logic [63:0] atg;
    } ment_t;

    ment_t       mq[$];
    logic [2:0]  m_tail;
    int unsigned m_ret, m_mis;
    int unsigned n_checks = 0, n_pass = 0;
    logic [2:0]  last_tag;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic bit is_mispred(input ment_t e);
        return (e.at != e.pt) || (e.at && (e.atg != e.ptg));
    endfunction

    function automatic bit head_mispred();
        return (mq.size() > 0) && mq[0].res && is_mispred(mq[0]);
    endfunction

    task automatic check_stats(input string tag);
`ifdef BR_RESOLVE_STATS_EN
        check({tag, "_ret"}, bus.stat_retired, m_ret);
        check({tag, "_mis"}, bus.stat_mispred, m_mis);
`else
        check({tag, "_ret"}, bus.stat_retired, 0);
        check({tag, "_mis"}, bus.stat_mispred, 0);
`endif
    endtask

    // One clock: drive at negedge, check combinational view, advance model, check registered view.
    task automatic step(input bit av, input logic [63:0] pc, input logic [3:0] idx,
                        input bit pt, input logic [63:0] ptg,
                        input bit rv, input logic [2:0] rtag, input bit rt, input logic [63:0] rtg);
        bit ready, ret, mis;
        ment_t h, n;
        @(negedge clk);
        bus.alloc_valid       = av;
        bus.alloc_pc          = pc;
        bus.alloc_idx         = idx;
        bus.alloc_pred_taken  = pt;
        bus.alloc_pred_target = ptg;
        bus.resolve_valid     = rv;
        bus.resolve_tag       = rtag;
        bus.resolve_taken     = rt;
        bus.resolve_target    = rtg;
        #1;
        ready = (mq.size() != DEPTH) && !head_mispred();
        check("alloc_ready", bus.alloc_ready, ready);
        check("alloc_tag", bus.alloc_tag, m_tail);
        check("count", bus.count, mq.size());
        last_tag = m_tail;

        ret = (mq.size() > 0) && mq[0].res;
        mis = ret && is_mispred(mq[0]);
        if (ret) h = mq[0];
        if (rv && !mis) begin
            foreach (mq[i]) if (mq[i].tag == rtag && !mq[i].res) begin
                mq[i].res = 1; mq[i].at = rt; mq[i].atg = rtg;
            end
        end
        if (ret) begin
            m_ret++;
            if (mis) m_mis++;
        end
        if (mis) begin
            mq.delete();
            m_tail = 0;
        end else if (ret) begin
            void'(mq.pop_front());
        end
        if (av && ready) begin
            n = '{tag: m_tail, pc: pc, idx: idx, pt: pt, ptg: ptg, res: 0, at: 0, atg: 0};
            mq.push_back(n);
            m_tail++;
        end

        @(posedge clk);
        #1;
        check("upd_valid", bus.upd_valid, ret);
        check("flush_valid", bus.flush_valid, mis);
        if (ret) begin
            check("upd_idx", bus.upd_idx, h.idx);
            check("upd_taken", bus.upd_taken, h.at);
        end
        if (mis) check("flush_target", bus.flush_target, h.at ? h.atg : h.pc + 64'd4);
        check_stats("stat");
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alloc(input logic [63:0] pc, input logic [3:0] idx, input bit pt, input logic [63:0] ptg);
        step(1, pc, idx, pt, ptg, 0, 0, 0, 0);
    endtask

    task automatic resolve(input logic [2:0] tag, input bit t, input logic [63:0] tg);
        step(0, 0, 0, 0, 0, 1, tag, t, tg);
    endtask

    task automatic async_reset();
        @(negedge clk);
        bus.alloc_valid   = 0;
        bus.resolve_valid = 0;
        #2 reset = 1'b0;
        #1;
        check("rst_count", bus.count, 0);
        check("rst_ready", bus.alloc_ready, 1);
        check("rst_tag", bus.alloc_tag, 0);
        check("rst_upd", bus.upd_valid, 0);
        check("rst_flush", bus.flush_valid, 0);
        mq.delete();
        m_tail = 0; m_ret = 0; m_mis = 0;
        check_stats("rst_stat");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [2:0] t0;
        int pend[$];
        bus.alloc_valid = 0; bus.alloc_pc = 0; bus.alloc_idx = 0;
        bus.alloc_pred_taken = 0; bus.alloc_pred_target = 0;
        bus.resolve_valid = 0; bus.resolve_tag = 0; bus.resolve_taken = 0; bus.resolve_target = 0;
        m_tail = 0; m_ret = 0; m_mis = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // reset mid-traffic, with an upd pulse in flight
        alloc(64'h40, 4'd5, 0, 0);
        alloc(64'h44, 4'd6, 1, 64'h80);
        resolve(3'd0, 0, 0);
        idle();
        async_reset();

        // correct path, out-of-order resolve
        alloc(64'h10, 4'd1, 0, 0);
        alloc(64'h20, 4'd2, 0, 0);
        alloc(64'h30, 4'd3, 0, 0);
        resolve(3'd2, 0, 0);
        resolve(3'd0, 0, 0);
        resolve(3'd1, 0, 0);
        repeat (3) idle();

        // direction mispredict
        alloc(64'h100, 4'd7, 0, 0);
        t0 = last_tag;
        resolve(t0, 1, 64'h200);
        idle();
        check("t3_flush_tgt", bus.flush_target, 64'h200);
        check("t3_upd_taken", bus.upd_taken, 1);
        idle();

        // target mispredict with younger pending entries
        alloc(64'h180, 4'd8, 1, 64'h300);
        t0 = last_tag;
        alloc(64'h184, 4'd9, 0, 0);
        alloc(64'h188, 4'd10, 1, 64'h900);
        resolve(t0, 1, 64'h340);
        idle();
        check("t4_flush_tgt", bus.flush_target, 64'h340);
        repeat (2) idle();

        // fill, blocked alloc while head retires, then streaming wrap
        for (int i = 0; i < DEPTH; i++) alloc(64'h1000 + 64'(i * 4), 4'(i), 0, 0);
        check("t5_full_ready", bus.alloc_ready, 0);
        step(1, 64'h2000, 4'd1, 0, 0, 1, mq[0].tag, 0, 0);
        step(1, 64'h2004, 4'd2, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 20; c++) begin
            t0 = 0;
            foreach (mq[i]) if (!mq[i].res) begin t0 = mq[i].tag; break; end
            step(1, 64'h3000 + 64'(c * 4), 4'(c), 0, 0, 1, t0, 0, 0);
        end

        // stats: 10 retires, 3 mispredicts
        async_reset();
        for (int i = 0; i < 10; i++) begin
            alloc(64'h4000 + 64'(i * 16), 4'(i), 0, 0);
            t0 = last_tag;
            resolve(t0, (i % 3 == 0) && (i < 9), 64'h500);
            repeat (2) idle();
        end
`ifdef BR_RESOLVE_STATS_EN
        check("t6_retired", bus.stat_retired, 10);
        check("t6_mispred", bus.stat_mispred, 3);
`else
        check("t6_retired", bus.stat_retired, 0);
        check("t6_mispred", bus.stat_mispred, 0);
`endif

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            bit av, pt, rv, rt;
            logic [63:0] ptg, rtg, pc;
            logic [2:0] rtag;
            int k;
            av  = ($urandom_range(0, 9) < 6);
            pc  = {$urandom(), $urandom() & 32'hFFFF_FFFC};
            pt  = $urandom_range(0, 1);
            ptg = $urandom_range(0, 1) ? 64'h1000 : 64'h2000;
            pend.delete();
            foreach (mq[i]) if (!mq[i].res) pend.push_back(i);
            rv = 0; rtag = 3'($urandom_range(0, 7)); rt = 0; rtg = 0;
            if (pend.size() > 0 && $urandom_range(0, 1)) begin
                k    = pend[$urandom_range(0, pend.size() - 1)];
                rv   = 1;
                rtag = mq[k].tag;
                rt   = ($urandom_range(0, 9) < 8) ? mq[k].pt : !mq[k].pt;
                rtg  = ($urandom_range(0, 9) < 8) ? mq[k].ptg : 64'hFFFF_FFFF_FFFF_FFFE;
            end else if ($urandom_range(0, 9) == 0) begin
                rv = 1; rt = $urandom_range(0, 1); rtg = 64'h1000;
            end
            step(av, pc, 4'($urandom_range(0, 15)), pt, ptg, rv, rtag, rt, rtg);
        end
        repeat (4) idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
